// File: rtl/draw_map_tiled_if.sv
// VGA timing + colour bundle passed along the video overlay chain.
// Latency: none, plain wiring bundle.
// Backpressure: none, the pixel stream never stalls.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_map_tiled.sv
// Tiled map renderer: tile RAM with write port and clear sweep, colour lookup per pixel.
// Latency: 3 clocks from vga_in to vga_out, timing fields delayed identically.
// Backpressure: wr_ready low during a clear sweep; writes offered then are dropped.
module draw_map_tiled #(
  parameter int          MAP_W        = 32,
  parameter int          MAP_H        = 24,
  parameter int          TILE_LOG2    = 5,
  parameter int          N_PLAYERS    = 4,
  parameter int          BLINK_FRAMES = 15,
  parameter logic [11:0] WALL_COLOR   = 12'h888,
  parameter logic [11:0] EMPTY_COLOR  = 12'h000,
  parameter logic [11:0] HEAD_COLOR   = 12'hFFF,
  parameter logic [11:0] GRID_COLOR   = 12'h222,
  parameter logic [11:0] OUT_COLOR    = 12'h000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(MAP_W)-1:0]      wr_x,
  input  logic [$clog2(MAP_H)-1:0]      wr_y,
  input  logic [3:0]                    wr_tile,
  output logic                          wr_ready,
  input  logic                          clear_req,
  output logic                          busy,
  output logic                          clear_done,
  input  logic [N_PLAYERS-1:0][11:0]    palette,
  input  logic                          grid_en,
  input  logic                          blink_en,
  vga_if.in                             vga_in,
  vga_if.out                            vga_out
);

  localparam int N_TILES = MAP_W * MAP_H;
  localparam int AW      = $clog2(N_TILES);
  localparam int TW      = 11 - TILE_LOG2;
  localparam int CW      = $clog2(BLINK_FRAMES + 1);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } timing_t;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  // ---------------- clear sweep FSM ----------------
  state_t          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            clear_done_q, clear_done_d;

  // Reset lands directly in CLEAR so the power-on sweep starts on the first clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Next state: one tile per clock, done pulse as the last address is written.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clear_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (32'(clr_addr_q) == N_TILES - 1) begin
          state_d      = ST_IDLE;
          clr_addr_d   = '0;
          clear_done_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q == ST_CLEAR);
  assign wr_ready   = !busy;
  assign clear_done = clear_done_q;

  // ---------------- tile RAM ----------------
  logic [3:0]    mem [N_TILES];
  logic          wr_in_range;
  logic [AW-1:0] wr_addr;

  assign wr_in_range = (32'(wr_x) < MAP_W) && (32'(wr_y) < MAP_H);
  assign wr_addr     = AW'(32'(wr_y) * MAP_W + 32'(wr_x));

  // Write port: the sweep owns the RAM while busy, user writes only when idle.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr_q] <= 4'h0;
    end else if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_tile;
    end
  end

  // ---------------- S1: tile coordinates and flags ----------------
  timing_t         tim_in;
  logic [TW-1:0]   tx_c, ty_c;
  logic [TW-1:0]   tx_s1_q, ty_s1_q;
  logic            in_map_s1_q, border_s1_q, grid_s1_q;
  timing_t         tim_s1_q;

  assign tim_in = '{hcount: vga_in.hcount, vcount: vga_in.vcount, hsync: vga_in.hsync,
                    vsync: vga_in.vsync, hblnk: vga_in.hblnk, vblnk: vga_in.vblnk};
  assign tx_c   = vga_in.hcount[10:TILE_LOG2];
  assign ty_c   = vga_in.vcount[10:TILE_LOG2];

  // Register tile coordinates plus map/border/grid classification of the pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_s1_q     <= '0;
      ty_s1_q     <= '0;
      in_map_s1_q <= 1'b0;
      border_s1_q <= 1'b0;
      grid_s1_q   <= 1'b0;
      tim_s1_q    <= '0;
    end else begin
      tx_s1_q     <= tx_c;
      ty_s1_q     <= ty_c;
      in_map_s1_q <= (32'(tx_c) < MAP_W) && (32'(ty_c) < MAP_H);
      border_s1_q <= (tx_c == '0) || (32'(tx_c) == MAP_W - 1) ||
                     (ty_c == '0) || (32'(ty_c) == MAP_H - 1);
      grid_s1_q   <= (vga_in.hcount[TILE_LOG2-1:0] == '0) ||
                     (vga_in.vcount[TILE_LOG2-1:0] == '0);
      tim_s1_q    <= tim_in;
    end
  end

  // ---------------- S2: RAM read ----------------
  logic [AW-1:0] rd_addr;
  logic [3:0]    tile_s2_q;
  logic          in_map_s2_q, border_s2_q, grid_s2_q;
  timing_t       tim_s2_q;

  // Off-map pixels read address 0 so the index never leaves the array.
  assign rd_addr = in_map_s1_q ? AW'(32'(ty_s1_q) * MAP_W + 32'(tx_s1_q)) : '0;

  // Synchronous read; a same-edge write is not visible (read-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_s2_q   <= '0;
      in_map_s2_q <= 1'b0;
      border_s2_q <= 1'b0;
      grid_s2_q   <= 1'b0;
      tim_s2_q    <= '0;
    end else begin
      tile_s2_q   <= mem[rd_addr];
      in_map_s2_q <= in_map_s1_q;
      border_s2_q <= border_s1_q;
      grid_s2_q   <= grid_s1_q;
      tim_s2_q    <= tim_s1_q;
    end
  end

  // ---------------- blink counter ----------------
  logic          vsync_q;
  logic [CW-1:0] frame_cnt_q;
  logic          blink_phase_q;

  // Count vsync rising edges; toggle the head phase every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q       <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      vsync_q <= vga_in.vsync;
      if (vga_in.vsync && !vsync_q) begin
        if (32'(frame_cnt_q) == BLINK_FRAMES - 1) begin
          frame_cnt_q   <= '0;
          blink_phase_q <= !blink_phase_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------- S3: colour select ----------------
  logic        is_player;
  logic [11:0] player_col;
  logic [11:0] rgb_d, rgb_q;
  timing_t     tim_s3_q;

  // Priority: blanking, off-map, border, grid, blinking head, tile colour.
  always_comb begin
    is_player  = 1'b0;
    player_col = EMPTY_COLOR;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (32'(tile_s2_q[2:0]) == p + 2) begin
        is_player  = 1'b1;
        player_col = palette[p];
      end
    end
    rgb_d = EMPTY_COLOR;
    if (tim_s2_q.hblnk || tim_s2_q.vblnk)                       rgb_d = 12'h000;
    else if (!in_map_s2_q)                                      rgb_d = OUT_COLOR;
    else if (border_s2_q)                                       rgb_d = WALL_COLOR;
    else if (grid_en && grid_s2_q)                              rgb_d = GRID_COLOR;
    else if (is_player && tile_s2_q[3] && blink_en && blink_phase_q) rgb_d = HEAD_COLOR;
    else if (is_player)                                         rgb_d = player_col;
    else if (tile_s2_q[2:0] == 3'd1)                            rgb_d = WALL_COLOR;
    else                                                        rgb_d = EMPTY_COLOR;
  end

  // Output register for colour and the 3-clock delayed timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q    <= '0;
      tim_s3_q <= '0;
    end else begin
      rgb_q    <= rgb_d;
      tim_s3_q <= tim_s2_q;
    end
  end

  assign vga_out.hcount = tim_s3_q.hcount;
  assign vga_out.vcount = tim_s3_q.vcount;
  assign vga_out.hsync  = tim_s3_q.hsync;
  assign vga_out.vsync  = tim_s3_q.vsync;
  assign vga_out.hblnk  = tim_s3_q.hblnk;
  assign vga_out.vblnk  = tim_s3_q.vblnk;
  assign vga_out.rgb    = rgb_q;

endmodule

// File: tb/tb_draw_map_tiled.sv
// Bench for draw_map_tiled: spec-level pixel model with a delayed-expectation queue.
// Latency: expects every presented pixel 3 clocks later on vga_out.
// Backpressure: checks write drop and sweep length around clear/reset.
module tb_draw_map_tiled;
  localparam int MAP_W = 32;
  localparam int MAP_H = 24;
  localparam int NP    = 4;
  localparam int BF    = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                wr_en;
  logic [4:0]          wr_x;
  logic [4:0]          wr_y;
  logic [3:0]          wr_tile;
  logic                wr_ready;
  logic                clear_req;
  logic                busy;
  logic                clear_done;
  logic [NP-1:0][11:0] palette;
  logic                grid_en;
  logic                blink_en;

  vga_if vin();
  vga_if vout();

  draw_map_tiled #(.MAP_W(MAP_W), .MAP_H(MAP_H), .TILE_LOG2(5), .N_PLAYERS(NP),
                   .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_tile(wr_tile),
    .wr_ready(wr_ready), .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
    .palette(palette), .grid_en(grid_en), .blink_en(blink_en),
    .vga_in(vin), .vga_out(vout));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rises = 0;
  logic [3:0] mmap [MAP_H][MAP_W];

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic [25:0] tim;
    int          h;
    int          v;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic void clear_map();
    for (int y = 0; y < MAP_H; y++)
      for (int x = 0; x < MAP_W; x++) mmap[y][x] = 4'h0;
  endfunction

  // Colour a pixel must have according to the rendering rules.
  function automatic logic [11:0] model_rgb(int h, int v, bit hb, bit vb);
    int tx, ty, code;
    logic [3:0] t;
    if (hb || vb) return 12'h000;
    tx = h / 32;
    ty = v / 32;
    if (tx >= MAP_W || ty >= MAP_H) return 12'h000;
    if (tx == 0 || tx == MAP_W - 1 || ty == 0 || ty == MAP_H - 1) return 12'h888;
    if (grid_en && (h % 32 == 0 || v % 32 == 0)) return 12'h222;
    t = mmap[ty][tx];
    code = int'(t[2:0]);
    if (code == 1) return 12'h888;
    if (code >= 2 && code < 2 + NP) begin
      if (t[3] && blink_en && ((rises / BF) % 2 == 1)) return 12'hFFF;
      return palette[code - 2];
    end
    return 12'h000;
  endfunction

  task automatic pix(input int h, input int v, input bit hs, input bit vs, input bit hb, input bit vb);
    exp_t e;
    logic [10:0] h11, v11;
    h11 = 11'(h);
    v11 = 11'(v);
    vin.hcount = h11; vin.vcount = v11;
    vin.hsync = hs; vin.vsync = vs; vin.hblnk = hb; vin.vblnk = vb;
    vin.rgb = 12'h5A5;
    e.due = cyc + 3;
    e.rgb = model_rgb(h, v, hb, vb);
    e.tim = {h11, v11, hs, vs, hb, vb};
    e.h = h;
    e.v = v;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (vout.rgb !== e.rgb) begin
        n_bad++;
        $display("FAIL pix_rgb (%0d,%0d): got %h expected %h", e.h, e.v, vout.rgb, e.rgb);
      end
      n_cmp++;
      if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk} !== e.tim) begin
        n_bad++;
        $display("FAIL pix_timing (%0d,%0d): got %h expected %h", e.h, e.v,
                 {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, e.tim);
      end
    end
  end

  // Present one pixel, flush it out with blanked fillers, compare to a literal.
  task automatic probe(input int h, input int v, input logic [11:0] lit, input string nm);
    pix(h, v, 0, 0, 0, 0);
    pix(0, 700, 0, 0, 1, 1);
    pix(0, 700, 0, 0, 1, 1);
    check(nm, 32'(vout.rgb), 32'(lit));
    check({nm, "_hcount"}, 32'(vout.hcount), 32'(h));
  endtask

  task automatic scan_row(input int ty);
    int ox[4] = '{0, 1, 31, 17};
    int oy[4] = '{0, 1, 31, 6};
    for (int tx = 0; tx < MAP_W; tx++)
      for (int k = 0; k < 4; k++)
        pix(tx * 32 + ox[k], ty * 32 + oy[k], (tx % 3) == 0, 0, 0, 0);
  endtask

  task automatic scan_all();
    for (int ty = 0; ty < MAP_H; ty++) scan_row(ty);
    pix(1024, 10, 0, 0, 0, 0);
    pix(1100, 800, 1, 0, 0, 0);
    pix(500, 768, 0, 0, 0, 0);
    pix(2047, 2047, 0, 0, 0, 0);
    pix(200, 100, 1, 0, 1, 0);
    pix(200, 100, 0, 0, 0, 1);
  endtask

  task automatic vsync_pulse();
    repeat (3) pix(0, 600, 0, 0, 0, 1);
    repeat (2) pix(0, 601, 0, 1, 0, 1);
    repeat (3) pix(0, 602, 0, 0, 0, 1);
    rises++;
  endtask

  task automatic wr(input int x, input int y, input logic [3:0] t);
    wr_x = 5'(x); wr_y = 5'(y); wr_tile = t; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (x < MAP_W && y < MAP_H) mmap[y][x] = t;
  endtask

  // Watch a sweep to completion; optionally inject a write or clear_req at a given clock.
  task automatic sweep_watch(input int wr_at, input int req_at, output int nb, output int nd);
    nb = 0;
    nd = 0;
    for (int i = 0; i < 2000; i++) begin
      if (busy) nb++;
      if (clear_done) nd++;
      if (!busy && nd > 0) break;
      wr_en = (i == wr_at);
      if (i == wr_at) begin wr_x = 5'd2; wr_y = 5'd2; wr_tile = 4'h3; end
      clear_req = (i == req_at);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    clear_req = 1'b0;
  endtask

  int nb, nd;

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_tile = '0; clear_req = 1'b0;
    grid_en = 1'b0; blink_en = 1'b0;
    palette = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00};
    vin.hcount = 11'd300; vin.vcount = 11'd40; vin.hsync = 1'b1; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'h5A5;
    clear_map();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", 32'(vout.rgb), 32'h0);
    check("rst_hcount", 32'(vout.hcount), 32'h0);
    check("rst_hsync", 32'(vout.hsync), 32'h0);
    check("rst_clear_done", 32'(clear_done), 32'h0);

    // Power-on sweep.
    rst = 1'b1;
    sweep_watch(-1, -1, nb, nd);
    check("init_busy_clocks", 32'(nb), 32'd768);
    check("init_done_pulses", 32'(nd), 32'd1);
    check("init_wr_ready", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    check("init_done_width", 32'(clear_done), 32'd0);
    scan_all();
    probe(0, 0, 12'h888, "border_tl");
    probe(100, 100, 12'h000, "inside_empty");
    probe(1023, 767, 12'h888, "border_br");

    // Player tiles and other codes.
    wr(5, 3, 4'h2);
    wr(6, 3, 4'hA);
    wr(10, 10, 4'h7);
    wr(11, 10, 4'h1);
    wr(12, 10, 4'h5);
    wr(13, 10, 4'hF);
    wr(14, 10, 4'hB);
    wr(15, 10, 4'h4);
    wr(5, 24, 4'h2);
    wr(7, 31, 4'h3);
    probe(160, 96, 12'hF00, "p0_tile53");
    probe(223, 127, 12'hF00, "p0_tile63");
    probe(325, 325, 12'h000, "code7_empty");
    probe(357, 325, 12'h888, "code1_wall");
    probe(389, 325, 12'hFF0, "code5_p3");
    scan_all();

    // Grid lines.
    grid_en = 1'b1;
    probe(160, 100, 12'h222, "grid_col");
    probe(200, 96, 12'h222, "grid_row");
    probe(0, 64, 12'h888, "grid_border");
    probe(161, 97, 12'hF00, "grid_off_line");
    scan_all();
    grid_en = 1'b0;

    // Head blinking over four frames.
    blink_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      probe(200, 100, (f < 2) ? 12'hF00 : 12'hFFF, $sformatf("blink_head_f%0d", f));
      probe(170, 100, 12'hF00, $sformatf("blink_body_f%0d", f));
      probe(421, 325, 12'h000, $sformatf("blink_code7_f%0d", f));
      scan_row(3);
      scan_row(10);
      vsync_pulse();
    end

    // Clear with a dropped write and an ignored second request.
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    clear_map();
    sweep_watch(0, 300, nb, nd);
    check("clr_busy_clocks", 32'(nb), 32'd768);
    check("clr_done_pulses", 32'(nd), 32'd1);
    probe(70, 70, 12'h000, "clr_dropped_write");
    probe(170, 100, 12'h000, "clr_tile53");
    scan_all();

    // Reset in the middle of a sweep.
    wr(5, 3, 4'h2);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    clear_map();
    for (int i = 0; i < 100; i++) pix(5, 5, 0, 0, 0, 0);
    rst = 1'b0;
    q.delete();
    #1;
    check("midrst_rgb", 32'(vout.rgb), 32'h0);
    check("midrst_hcount", 32'(vout.hcount), 32'h0);
    check("midrst_clear_done", 32'(clear_done), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rises = 0;
    sweep_watch(-1, -1, nb, nd);
    check("rst_sweep_clocks", 32'(nb), 32'd768);
    check("rst_sweep_done", 32'(nd), 32'd1);
    scan_row(3);
    probe(170, 100, 12'h000, "rst_tile53");
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
